// File: rtl/ftdi_tx_arbiter_pkg.sv
// ftdi_tx_arbiter_pkg
//   Shared types and constants for the FTDI TX stream arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE / LOCKED)
//   BEAT_CNT_W  : width of the per-grant beat counter
package ftdi_tx_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  localparam int BEAT_CNT_W = 16;

endpackage

// File: rtl/ftdi_tx_arbiter_skid.sv
// axis_skid_buffer
//   Two-entry AXI-stream skid buffer. The outputs come straight from the
//   main register, and the upstream ready comes straight from the skid
//   register, so there is no combinational path from m_ready to s_ready.
//   Ports:
//     clk, rst_n        clock, async active-low reset (already synchronised)
//     s_valid/s_ready   upstream handshake, s_data payload in
//     m_valid/m_ready   downstream handshake, m_data payload out
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  logic             main_valid;
  logic [WIDTH-1:0] main_data;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;

  // Ready is the inverted skid occupancy: a flop output, one cycle late,
  // which is why the second entry is needed to absorb the in-flight beat.
  assign s_ready = ~skid_valid;
  assign m_valid = main_valid;
  assign m_data  = main_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!main_valid || m_ready) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= s_valid;
        if (s_valid) begin
          main_data <= s_data;
        end
      end
    end else if (s_valid && !skid_valid) begin
      skid_valid <= 1'b1;
      skid_data  <= s_data;
    end
  end

endmodule

// File: rtl/ftdi_tx_arbiter.sv
// ftdi_tx_arbiter
//   Packet-atomic round-robin arbiter in front of the FTDI 245-FIFO TX
//   AXI-stream port. A granted source keeps the port until its tlast beat
//   (or the optional MAXBEATS limit) is accepted.
//   Ports:
//     clk, rstn_async         user clock, async active-low reset
//     s_tvalid/s_tready       per-source handshake (s_tready one-hot or zero)
//     s_tdata/s_tkeep/s_tlast per-source payload, source i at [i*W +: W] etc.
//     m_t*                    registered stream to the FTDI TX port
//     grant_id                current or last granted source
//     busy                    high while a grant is held
//
//   state     | meaning
//   ST_IDLE   | no grant; pick next requester from rr_ptr, all s_tready low
//   ST_LOCKED | grant_id owns the output until release beat is accepted
module ftdi_tx_arbiter
  import ftdi_tx_arbiter_pkg::*;
#(
  parameter int EW       = 2,
  parameter int NSRC     = 3,
  parameter int MAXBEATS = 0
) (
  input  logic                     clk,
  input  logic                     rstn_async,
  input  logic [NSRC-1:0]          s_tvalid,
  output logic [NSRC-1:0]          s_tready,
  input  logic [NSRC*(8<<EW)-1:0]  s_tdata,
  input  logic [NSRC*(1<<EW)-1:0]  s_tkeep,
  input  logic [NSRC-1:0]          s_tlast,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [(8<<EW)-1:0]       m_tdata,
  output logic [(1<<EW)-1:0]       m_tkeep,
  output logic                     m_tlast,
  output logic [2:0]               grant_id,
  output logic                     busy
);

  localparam int W  = 8 << EW;
  localparam int K  = 1 << EW;
  localparam int DW = W + K + 1;

  localparam bit                  LIMIT_EN  = (MAXBEATS != 0);
  localparam logic [BEAT_CNT_W-1:0] BEAT_LAST =
    (MAXBEATS == 0) ? '0 : BEAT_CNT_W'(MAXBEATS - 1);
  localparam logic [BEAT_CNT_W-1:0] BEAT_MAX = '1;

  // Async assert, sync deassert of the internal reset.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge rstn_async) begin
    if (!rstn_async) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  arb_state_t              state, state_nx;
  logic [2:0]              rr_ptr, rr_nx;
  logic [2:0]              grant_q, grant_nx;
  logic [BEAT_CNT_W-1:0]   beat_cnt, cnt_nx;

  logic [2:0]  pick;
  logic        any_req;
  int          idx;

  // First requester at or after rr_ptr, wrapping modulo NSRC.
  always_comb begin
    pick    = rr_ptr;
    any_req = 1'b0;
    idx     = 0;
    for (int k = 0; k < NSRC; k++) begin
      idx = (int'(rr_ptr) + k) % NSRC;
      if (!any_req && s_tvalid[idx]) begin
        any_req = 1'b1;
        pick    = 3'(idx);
      end
    end
  end

  logic          g_valid;
  logic          g_last;
  logic [W-1:0]  g_data;
  logic [K-1:0]  g_keep;

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    g_keep  = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (grant_q == 3'(i)) begin
        g_valid = s_tvalid[i];
        g_last  = s_tlast[i];
        g_data  = s_tdata[i*W +: W];
        g_keep  = s_tkeep[i*K +: K];
      end
    end
  end

  logic          sb_in_valid;
  logic          sb_in_ready;
  logic [DW-1:0] sb_out_data;
  logic          hs;
  logic          release_now;

  assign sb_in_valid = (state == ST_LOCKED) && g_valid;
  assign hs          = sb_in_valid && sb_in_ready;
  assign release_now = hs && (g_last || (LIMIT_EN && (beat_cnt == BEAT_LAST)));

  always_comb begin
    s_tready = '0;
    if (state == ST_LOCKED) begin
      for (int i = 0; i < NSRC; i++) begin
        if (grant_q == 3'(i)) begin
          s_tready[i] = sb_in_ready;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      grant_q  <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nx;
      rr_ptr   <= rr_nx;
      grant_q  <= grant_nx;
      beat_cnt <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    rr_nx    = rr_ptr;
    grant_nx = grant_q;
    cnt_nx   = beat_cnt;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          grant_nx = pick;
          cnt_nx   = '0;
          state_nx = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (hs && (beat_cnt != BEAT_MAX)) begin
          cnt_nx = beat_cnt + 1'b1;
        end
        if (release_now) begin
          state_nx = ST_IDLE;
          rr_nx    = (grant_q == 3'(NSRC - 1)) ? 3'd0 : grant_q + 3'd1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  axis_skid_buffer #(
    .WIDTH(DW)
  ) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_valid(sb_in_valid),
    .s_ready(sb_in_ready),
    .s_data ({g_last, g_keep, g_data}),
    .m_valid(m_tvalid),
    .m_ready(m_tready),
    .m_data (sb_out_data)
  );

  assign m_tlast  = sb_out_data[DW-1];
  assign m_tkeep  = sb_out_data[W +: K];
  assign m_tdata  = sb_out_data[W-1:0];
  assign grant_id = grant_q;
  assign busy     = (state == ST_LOCKED);

endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
// tb_ftdi_tx_arbiter
//   Directed bench for ftdi_tx_arbiter. Two instances share the source-side
//   stimulus: u_dut (MAXBEATS=0) and u_dut_mb (MAXBEATS=4); sel chooses which
//   one's s_tready/m_* the source model and monitor follow.
module tb_ftdi_tx_arbiter;

  localparam int NSRC = 3;
  localparam int W    = 32;
  localparam int K    = 4;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  logic              clk;
  logic              rstn_async;
  logic [NSRC-1:0]   s_tvalid;
  logic [NSRC*W-1:0] s_tdata;
  logic [NSRC*K-1:0] s_tkeep;
  logic [NSRC-1:0]   s_tlast;
  logic              m_tready;
  logic              sel;

  logic [NSRC-1:0] a_tready, b_tready, o_tready;
  logic            a_tvalid, b_tvalid, o_tvalid;
  logic [W-1:0]    a_tdata, b_tdata, o_tdata;
  logic [K-1:0]    a_tkeep, b_tkeep, o_tkeep;
  logic            a_tlast, b_tlast, o_tlast;
  logic [2:0]      a_grant, b_grant, o_grant;
  logic            a_busy, b_busy, o_busy;

  ftdi_tx_arbiter #(.EW(2), .NSRC(NSRC), .MAXBEATS(0)) u_dut (
    .clk(clk), .rstn_async(rstn_async),
    .s_tvalid(s_tvalid), .s_tready(a_tready), .s_tdata(s_tdata),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .m_tvalid(a_tvalid), .m_tready(m_tready), .m_tdata(a_tdata),
    .m_tkeep(a_tkeep), .m_tlast(a_tlast),
    .grant_id(a_grant), .busy(a_busy)
  );

  ftdi_tx_arbiter #(.EW(2), .NSRC(NSRC), .MAXBEATS(4)) u_dut_mb (
    .clk(clk), .rstn_async(rstn_async),
    .s_tvalid(s_tvalid), .s_tready(b_tready), .s_tdata(s_tdata),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .m_tvalid(b_tvalid), .m_tready(m_tready), .m_tdata(b_tdata),
    .m_tkeep(b_tkeep), .m_tlast(b_tlast),
    .grant_id(b_grant), .busy(b_busy)
  );

  assign o_tready = sel ? b_tready : a_tready;
  assign o_tvalid = sel ? b_tvalid : a_tvalid;
  assign o_tdata  = sel ? b_tdata  : a_tdata;
  assign o_tkeep  = sel ? b_tkeep  : a_tkeep;
  assign o_tlast  = sel ? b_tlast  : a_tlast;
  assign o_grant  = sel ? b_grant  : a_grant;
  assign o_busy   = sel ? b_busy   : a_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Source model storage
  logic [31:0] sd  [NSRC][16];
  logic [3:0]  skp [NSRC][16];
  logic        sl  [NSRC][16];
  int          slen[NSRC];
  int          sidx[NSRC];
  int          gap_at[NSRC];
  int          gap_left[NSRC];
  bit          rand_rdy;

  // Monitor state
  beat_t      rxq[$];
  beat_t      exp_q[$];
  logic [2:0] gq[$];
  int         cyc, first_mv, last_mv, stab_err;
  logic       prev_busy, prev_stall;
  beat_t      prev_m;

  task automatic clear_src();
    for (int i = 0; i < NSRC; i++) begin
      slen[i] = 0; sidx[i] = 0; gap_at[i] = -1; gap_left[i] = 0;
    end
    rxq.delete(); exp_q.delete(); gq.delete();
    cyc = 0; first_mv = -1; last_mv = -1; stab_err = 0;
    prev_busy = 1'b0; prev_stall = 1'b0; prev_m = '0;
    rand_rdy = 1'b0;
  endtask

  task automatic put_beat(input int s, input logic [31:0] d, input logic [3:0] k, input logic l);
    sd[s][slen[s]]  = d;
    skp[s][slen[s]] = k;
    sl[s][slen[s]]  = l;
    slen[s]++;
  endtask

  task automatic drive();
    for (int i = 0; i < NSRC; i++) begin
      if (sidx[i] < slen[i]) begin
        if (sidx[i] == gap_at[i] && gap_left[i] > 0) begin
          gap_left[i]--;
          s_tvalid[i] = 1'b0;
        end else begin
          s_tvalid[i]        = 1'b1;
          s_tdata[i*W +: W]  = sd[i][sidx[i]];
          s_tkeep[i*K +: K]  = skp[i][sidx[i]];
          s_tlast[i]         = sl[i][sidx[i]];
        end
      end else begin
        s_tvalid[i] = 1'b0;
      end
    end
    m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic sample();
    beat_t cur;
    cur = {o_tdata, o_tkeep, o_tlast};
    if (prev_stall && (!o_tvalid || cur != prev_m)) stab_err++;
    prev_stall = o_tvalid && !m_tready;
    prev_m     = cur;
    if (o_tvalid && m_tready) rxq.push_back(cur);
    if (o_tvalid) begin
      if (first_mv < 0) first_mv = cyc;
      last_mv = cyc;
    end
    if (o_busy && !prev_busy) gq.push_back(o_grant);
    prev_busy = o_busy;
    for (int i = 0; i < NSRC; i++) begin
      if (s_tvalid[i] && o_tready[i]) sidx[i]++;
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    sample();
  endtask

  function automatic bit drained();
    bit r;
    r = 1'b1;
    for (int i = 0; i < NSRC; i++) if (sidx[i] < slen[i]) r = 1'b0;
    return r;
  endfunction

  task automatic run(input int budget, input string tag);
    bit done;
    int n;
    done = 1'b0;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
      done = drained() && !o_tvalid && !o_busy;
    end
    if (!done) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rstn_async = 1'b0;
    s_tvalid   = '0;
    m_tready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstn_async = 1'b1;
    repeat (4) @(posedge clk);
    clear_src();
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_nbeats"}, 64'(rxq.size()), 64'(exp_q.size()));
    for (int j = 0; j < rxq.size() && j < exp_q.size(); j++) begin
      chk($sformatf("%s_beat%0d", tag, j), 64'(rxq[j]), 64'(exp_q[j]));
    end
  endtask

  task automatic cmp_grants(input string tag, input logic [2:0] e0, input logic [2:0] e1,
                            input logic [2:0] e2, input int n);
    logic [2:0] e[3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    chk({tag, "_ngrants"}, 64'(gq.size()), 64'(n));
    for (int j = 0; j < n && j < 3 && j < gq.size(); j++) begin
      chk($sformatf("%s_grant%0d", tag, j), 64'(gq[j]), 64'(e[j]));
    end
  endtask

  initial begin
    rstn_async = 1'b1;
    s_tvalid   = '0;
    s_tdata    = '0;
    s_tkeep    = '0;
    s_tlast    = '0;
    m_tready   = 1'b1;
    sel        = 1'b0;
    clear_src();

    // Reset state
    #2 rstn_async = 1'b0;
    #20;
    chk("rst_m_tvalid", 64'(a_tvalid), 64'd0);
    chk("rst_s_tready", 64'(a_tready), 64'd0);
    chk("rst_busy",     64'(a_busy),   64'd0);
    chk("rst_grant_id", 64'(a_grant),  64'd0);
    chk("rst_m_tdata",  64'(a_tdata),  64'd0);
    chk("rst_m_tkeep",  64'(a_tkeep),  64'd0);
    chk("rst_m_tlast",  64'(a_tlast),  64'd0);
    chk("rst_mb_tvalid", 64'(b_tvalid), 64'd0);
    rstn_async = 1'b1;
    repeat (4) @(posedge clk);

    // Single source, 4 beats from source 1
    sel = 1'b0;
    apply_reset();
    put_beat(1, 32'h11111111, 4'hF, 1'b0);
    put_beat(1, 32'h22222222, 4'hF, 1'b0);
    put_beat(1, 32'h33333333, 4'hF, 1'b0);
    put_beat(1, 32'h44444444, 4'hF, 1'b1);
    for (int b = 0; b < 4; b++) exp_q.push_back({sd[1][b], skp[1][b], sl[1][b]});
    run(100, "single");
    chk("single_first_mvalid_cyc", 64'(first_mv), 64'd2);
    cmp_grants("single", 3'd1, 3'd0, 3'd0, 1);
    cmp_stream("single");

    // Round robin, 4 packets of 2 beats per source
    apply_reset();
    for (int s = 0; s < NSRC; s++)
      for (int p = 0; p < 4; p++)
        for (int b = 0; b < 2; b++)
          put_beat(s, {8'(s), 8'(p), 8'(b), 8'hA5}, 4'hF, b == 1);
    for (int j = 0; j < 24; j++)
      exp_q.push_back({8'((j / 2) % 3), 8'((j / 2) / 3), 8'(j % 2), 8'hA5, 4'hF, 1'(j % 2)});
    run(300, "rr");
    cmp_grants("rr", 3'd0, 3'd1, 3'd2, 12);
    if (gq.size() >= 6) begin
      chk("rr_grant3", 64'(gq[3]), 64'd0);
      chk("rr_grant5", 64'(gq[5]), 64'd2);
    end
    chk("rr_valid_span", 64'(last_mv - first_mv), 64'd34);
    cmp_stream("rr");

    // Back-pressure, 8 beats from source 2, short keep on last beat
    apply_reset();
    for (int b = 0; b < 8; b++)
      put_beat(2, 32'hC0DE0000 + 32'(b), (b == 7) ? 4'b0011 : 4'hF, b == 7);
    for (int b = 0; b < 8; b++) exp_q.push_back({sd[2][b], skp[2][b], sl[2][b]});
    rand_rdy = 1'b1;
    run(400, "bp");
    chk("bp_stable_while_stalled", 64'(stab_err), 64'd0);
    cmp_grants("bp", 3'd2, 3'd0, 3'd0, 1);
    cmp_stream("bp");

    // MAXBEATS=4: src0 10 beats, src1 waits with 1 beat
    sel = 1'b1;
    apply_reset();
    for (int b = 0; b < 10; b++) put_beat(0, 32'hA0000000 + 32'(b), 4'hF, b == 9);
    put_beat(1, 32'hB1000000, 4'hF, 1'b1);
    for (int b = 0; b < 4; b++) exp_q.push_back({sd[0][b], 4'hF, 1'b0});
    exp_q.push_back({32'hB1000000, 4'hF, 1'b1});
    for (int b = 4; b < 10; b++) exp_q.push_back({sd[0][b], 4'hF, 1'(b == 9)});
    run(200, "maxb");
    chk("maxb_ngrants", 64'(gq.size()), 64'd4);
    if (gq.size() == 4) begin
      chk("maxb_grant0", 64'(gq[0]), 64'd0);
      chk("maxb_grant1", 64'(gq[1]), 64'd1);
      chk("maxb_grant2", 64'(gq[2]), 64'd0);
      chk("maxb_grant3", 64'(gq[3]), 64'd0);
    end
    cmp_stream("maxb");

    // Mid-packet stall of source 0 while source 2 requests
    sel = 1'b0;
    apply_reset();
    for (int b = 0; b < 5; b++) put_beat(0, 32'hD0000000 + 32'(b), 4'hF, b == 4);
    for (int b = 0; b < 2; b++) put_beat(2, 32'hD2000000 + 32'(b), 4'hF, b == 1);
    gap_at[0] = 2;
    gap_left[0] = 20;
    for (int b = 0; b < 5; b++) exp_q.push_back({sd[0][b], 4'hF, 1'(b == 4)});
    for (int b = 0; b < 2; b++) exp_q.push_back({sd[2][b], 4'hF, 1'(b == 1)});
    run(200, "stall");
    cmp_grants("stall", 3'd0, 3'd2, 3'd0, 2);
    cmp_stream("stall");

    // Reset mid-packet; rr_ptr is left at 2 beforehand so a missed reset shows
    apply_reset();
    put_beat(1, 32'hE1000000, 4'hF, 1'b1);
    run(50, "pre");
    clear_src();
    for (int b = 0; b < 6; b++) put_beat(2, 32'hE2000000 + 32'(b), 4'hF, b == 5);
    begin
      int n;
      n = 0;
      while (sidx[2] < 3 && n < 50) begin
        tick();
        n++;
      end
      if (sidx[2] < 3) chk("rstmid_reach_beat3_timeout", 64'd0, 64'd1);
    end
    @(posedge clk);
    #1;
    rstn_async = 1'b0;
    s_tvalid   = '0;
    #1;
    chk("rstmid_m_tvalid", 64'(a_tvalid), 64'd0);
    chk("rstmid_s_tready", 64'(a_tready), 64'd0);
    chk("rstmid_busy",     64'(a_busy),   64'd0);
    clear_src();
    repeat (3) @(posedge clk);
    #1;
    rstn_async = 1'b1;
    repeat (4) @(posedge clk);
    put_beat(0, 32'hF0000000, 4'hF, 1'b1);
    put_beat(1, 32'hF1000000, 4'hF, 1'b1);
    put_beat(2, 32'hF2000000, 4'hF, 1'b1);
    exp_q.push_back({32'hF0000000, 4'hF, 1'b1});
    exp_q.push_back({32'hF1000000, 4'hF, 1'b1});
    exp_q.push_back({32'hF2000000, 4'hF, 1'b1});
    run(100, "postrst");
    cmp_grants("postrst", 3'd0, 3'd1, 3'd2, 3);
    cmp_stream("postrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
